// File: rtl/conv_window_feeder_if.sv
// rtl/conv_window_feeder_if.sv - pixel-in / window-out handshake bundle for conv_window_feeder
//
// Purpose: groups the pixel stream, the 5x5 window stream and the frame
// markers of conv_window_feeder into one interface.
// Signals:
//   in_data/in_valid/in_ready                      raster pixel stream into the feeder
//   win_data/win_valid/win_ready/win_first/win_last window stream to the compute unit
//   frame_done                                     one-cycle end-of-frame pulse
//   result_valid/result_last                       only with FEEDER_RESULT_ALIGN_EN defined
// Modports: master = feeder side, slave = pixel source / window consumer side.
interface conv_window_feeder_if #(
  parameter int DATA_WIDTH = 16,
  parameter int TAPS       = 25
);
  logic [DATA_WIDTH-1:0]      in_data;
  logic                       in_valid;
  logic                       in_ready;
  logic [TAPS*DATA_WIDTH-1:0] win_data;
  logic                       win_valid;
  logic                       win_ready;
  logic                       win_first;
  logic                       win_last;
  logic                       frame_done;
`ifdef FEEDER_RESULT_ALIGN_EN
  logic                       result_valid;
  logic                       result_last;

  modport master (
    input  in_data, in_valid, win_ready,
    output in_ready, win_data, win_valid, win_first, win_last, frame_done,
           result_valid, result_last
  );
  modport slave (
    output in_data, in_valid, win_ready,
    input  in_ready, win_data, win_valid, win_first, win_last, frame_done,
           result_valid, result_last
  );
`else
  modport master (
    input  in_data, in_valid, win_ready,
    output in_ready, win_data, win_valid, win_first, win_last, frame_done
  );
  modport slave (
    output in_data, in_valid, win_ready,
    input  in_ready, win_data, win_valid, win_first, win_last, frame_done
  );
`endif
endinterface

// File: rtl/conv_window_feeder.sv
// rtl/conv_window_feeder.sv - 5x5 sliding-window producer for the convolution datapath
//
// Purpose: takes a raster-order pixel stream, keeps four line buffers and a
// 5x5 register window, and emits one full window (25 pixels in parallel) per
// valid output position (stride 1, no padding) with valid/ready flow control.
// Ports:
//   clk                 single clock, posedge
//   rst                 synchronous active-high reset
//   bus.in_data/in_valid/in_ready               pixel stream (in_ready = !win_valid || win_ready)
//   bus.win_data/win_valid/win_ready            window; slice k = 5*row + col, row 0 oldest, col 0 leftmost
//   bus.win_first/win_last                      first / last window of the frame
//   bus.frame_done                              pulse the cycle after the last pixel of a frame
//   bus.result_valid/result_last                window / last-window handshakes delayed by
//                                               MAC_LATENCY cycles (FEEDER_RESULT_ALIGN_EN only)
// Optional feature macro: FEEDER_RESULT_ALIGN_EN
module conv_window_feeder #(
  parameter int DATA_WIDTH    = 16,
  parameter int FILTER_WIDTH  = 5,
  parameter int INPUT_WIDTH   = 32,
  parameter int INPUT_HEIGTH  = 32,
  parameter int OUTPUT_WIDTH  = 28,
  parameter int OUTPUT_HEIGTH = 28,
  parameter int MAC_LATENCY   = 6
) (
  input  logic                 clk,
  input  logic                 rst,
  conv_window_feeder_if.master bus
);
  localparam int TAPS  = FILTER_WIDTH * FILTER_WIDTH;
  localparam int LINES = FILTER_WIDTH - 1;
  localparam int COL_W = (INPUT_WIDTH > 1) ? $clog2(INPUT_WIDTH) : 1;
  localparam int ROW_W = (INPUT_HEIGTH > 1) ? $clog2(INPUT_HEIGTH) : 1;

  localparam logic [COL_W-1:0] COL_LAST = COL_W'(INPUT_WIDTH - 1);
  localparam logic [ROW_W-1:0] ROW_LAST = ROW_W'(INPUT_HEIGTH - 1);
  // Input position whose acceptance completes the first / last window.
  localparam logic [COL_W-1:0] COL_WIN0 = COL_W'(FILTER_WIDTH - 1);
  localparam logic [ROW_W-1:0] ROW_WIN0 = ROW_W'(FILTER_WIDTH - 1);
  localparam logic [COL_W-1:0] COL_WINL = COL_W'(OUTPUT_WIDTH + FILTER_WIDTH - 2);
  localparam logic [ROW_W-1:0] ROW_WINL = ROW_W'(OUTPUT_HEIGTH + FILTER_WIDTH - 2);

  generate
    if (FILTER_WIDTH != 5) begin : g_bad_filter
      $error("conv_window_feeder supports only FILTER_WIDTH = 5");
    end
    if ((OUTPUT_WIDTH != INPUT_WIDTH - FILTER_WIDTH + 1) ||
        (OUTPUT_HEIGTH != INPUT_HEIGTH - FILTER_WIDTH + 1)) begin : g_bad_output
      $error("conv_window_feeder OUTPUT_* must equal INPUT_* - FILTER_WIDTH + 1");
    end
    if (MAC_LATENCY < 1) begin : g_bad_latency
      $error("conv_window_feeder MAC_LATENCY must be at least 1");
    end
  endgenerate

  typedef logic [DATA_WIDTH-1:0] pix_t;

  pix_t                       lb_q  [LINES][INPUT_WIDTH];
  pix_t                       lb_d  [LINES][INPUT_WIDTH];
  pix_t                       win_q [TAPS];
  pix_t                       win_d [TAPS];
  logic [COL_W-1:0]           col_q, col_d;
  logic [ROW_W-1:0]           row_q, row_d;
  logic [TAPS*DATA_WIDTH-1:0] win_data_q, win_data_d;
  logic                       win_valid_q, win_valid_d;
  logic                       win_first_q, win_first_d;
  logic                       win_last_q, win_last_d;
  logic                       frame_done_q, frame_done_d;

  logic in_ready;
  logic accept;
  logic load;

  // Gated by rst so no pixel can slip in while a stale window is being cleared.
  assign in_ready = !rst && (!win_valid_q || bus.win_ready);
  assign accept   = bus.in_valid && in_ready;
  // Pixels left of / above the first full window only prime the buffers.
  assign load     = accept && (row_q >= ROW_WIN0) && (col_q >= COL_WIN0);

  always_comb begin
    col_d        = col_q;
    row_d        = row_q;
    lb_d         = lb_q;
    win_d        = win_q;
    win_data_d   = win_data_q;
    win_first_d  = win_first_q;
    win_last_d   = win_last_q;
    win_valid_d  = win_valid_q && !bus.win_ready;
    frame_done_d = 1'b0;

    if (accept) begin
      for (int r = 0; r < FILTER_WIDTH; r++) begin
        for (int c = 0; c < FILTER_WIDTH - 1; c++) begin
          win_d[r*FILTER_WIDTH + c] = win_q[r*FILTER_WIDTH + c + 1];
        end
      end
      // New right column, oldest line on top, incoming pixel at the bottom.
      for (int r = 0; r < LINES; r++) begin
        win_d[r*FILTER_WIDTH + FILTER_WIDTH - 1] = lb_q[LINES-1-r][col_q];
      end
      win_d[TAPS-1] = bus.in_data;

      for (int i = LINES - 1; i > 0; i--) begin
        lb_d[i][col_q] = lb_q[i-1][col_q];
      end
      lb_d[0][col_q] = bus.in_data;

      if (col_q == COL_LAST) begin
        col_d = '0;
        if (row_q == ROW_LAST) begin
          row_d        = '0;
          frame_done_d = 1'b1;
        end else begin
          row_d = row_q + 1'b1;
        end
      end else begin
        col_d = col_q + 1'b1;
      end

      if (load) begin
        win_valid_d = 1'b1;
        for (int k = 0; k < TAPS; k++) begin
          win_data_d[k*DATA_WIDTH +: DATA_WIDTH] = win_d[k];
        end
        win_first_d = (row_q == ROW_WIN0) && (col_q == COL_WIN0);
        win_last_d  = (row_q == ROW_WINL) && (col_q == COL_WINL);
      end
    end
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      col_q        <= '0;
      row_q        <= '0;
      win_data_q   <= '0;
      win_valid_q  <= 1'b0;
      win_first_q  <= 1'b0;
      win_last_q   <= 1'b0;
      frame_done_q <= 1'b0;
      for (int k = 0; k < TAPS; k++) begin
        win_q[k] <= '0;
      end
    end else begin
      col_q        <= col_d;
      row_q        <= row_d;
      win_data_q   <= win_data_d;
      win_valid_q  <= win_valid_d;
      win_first_q  <= win_first_d;
      win_last_q   <= win_last_d;
      frame_done_q <= frame_done_d;
      win_q        <= win_d;
    end
  end

  // Line buffer contents are never reset; stale rows are overwritten before
  // they can reach a window.
  always_ff @(posedge clk) begin
    lb_q <= lb_d;
  end

  assign bus.in_ready   = in_ready;
  assign bus.win_data   = win_data_q;
  assign bus.win_valid  = win_valid_q;
  assign bus.win_first  = win_first_q;
  assign bus.win_last   = win_last_q;
  assign bus.frame_done = frame_done_q;

`ifdef FEEDER_RESULT_ALIGN_EN
  logic [MAC_LATENCY-1:0] res_valid_q, res_valid_d;
  logic [MAC_LATENCY-1:0] res_last_q, res_last_d;

  // Handshake events enter the delay line in the cycle they occur.
  always_comb begin
    res_valid_d = MAC_LATENCY'({res_valid_q, win_valid_q && bus.win_ready});
    res_last_d  = MAC_LATENCY'({res_last_q, win_valid_q && win_last_q && bus.win_ready});
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      res_valid_q <= '0;
      res_last_q  <= '0;
    end else begin
      res_valid_q <= res_valid_d;
      res_last_q  <= res_last_d;
    end
  end

  assign bus.result_valid = res_valid_q[MAC_LATENCY-1];
  assign bus.result_last  = res_last_q[MAC_LATENCY-1];
`endif
endmodule
